// File: rtl/ldst_lane_queue.sv
// Per-lane load/store request queue: FIFO buffering, in-order memory issue with at most one
// outstanding load, store byte-lane formatting and registered load writeback.
module ldst_lane_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 7,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            in_valid_i,
  input  logic [ADDR_W+REG_W+DATA_W+3:0]  in_packet_i,
  input  logic                            in_is_store_i,
  output logic                            in_ready_o,
  output logic                            mem_req_valid_o,
  input  logic                            mem_req_ready_i,
  output logic                            mem_req_we_o,
  output logic [ADDR_W-1:0]               mem_req_addr_o,
  output logic [31:0]                     mem_req_wdata_o,
  output logic [3:0]                      mem_req_be_o,
  output logic [1:0]                      mem_req_space_o,
  input  logic                            mem_rsp_valid_i,
  input  logic [31:0]                     mem_rsp_data_i,
  output logic                            wb_valid_o,
  output logic [REG_W-1:0]                wb_reg_o,
  output logic [31:0]                     wb_data_o,
  output logic                            busy_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int unsigned PktW    = ADDR_W + REG_W + DATA_W + 4;
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned WdataLo = 4;
  localparam int unsigned RegLo   = 4 + DATA_W;
  localparam int unsigned AddrLo  = 4 + DATA_W + REG_W;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StWaitRsp} state_e;

  state_e             state_q, state_d;
  logic [PktW:0]      fifo_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [REG_W-1:0]   ld_reg_q, ld_reg_d;
  logic [1:0]         ld_off_q, ld_off_d;
  logic [1:0]         ld_size_q, ld_size_d;
  logic               wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]   wb_reg_q, wb_reg_d;
  logic [31:0]        wb_data_q, wb_data_d;

  logic               push, pop, req_hs;
  logic [PktW:0]      head;
  logic [ADDR_W-1:0]  h_addr;
  logic [REG_W-1:0]   h_reg;
  logic [31:0]        h_wdata;
  logic [1:0]         h_space, h_size;
  logic               h_store;
  logic [31:0]        st_wdata;
  logic [3:0]         st_be;
  logic [31:0]        rsp_shift, ld_data;

  // Entry layout: {is_store, addr, reg, wdata, space, size}
  assign head    = fifo_q[rd_ptr_q];
  assign h_size  = head[1:0];
  assign h_space = head[3:2];
  assign h_wdata = head[WdataLo +: 32];
  assign h_reg   = head[RegLo +: REG_W];
  assign h_addr  = head[AddrLo +: ADDR_W];
  assign h_store = head[PktW];

  assign in_ready_o      = (count_q != Full);
  assign mem_req_valid_o = (state_q == StIdle) && (count_q != '0);
  assign req_hs          = mem_req_valid_o & mem_req_ready_i;
  assign push            = in_valid_i & in_ready_o;
  assign pop             = req_hs;

  assign mem_req_we_o    = h_store;
  assign mem_req_addr_o  = {h_addr[ADDR_W-1:2], 2'b00};
  assign mem_req_space_o = h_space;
  assign mem_req_wdata_o = st_wdata;
  assign mem_req_be_o    = h_store ? st_be : 4'hF;

  always_comb begin
    st_wdata = h_wdata;
    st_be    = 4'hF;
    case (h_size)
      2'b10: begin
        st_wdata = {4{h_wdata[7:0]}};
        st_be    = 4'b0001 << h_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{h_wdata[15:0]}};
        st_be    = h_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign rsp_shift = mem_rsp_data_i >> {ld_off_q, 3'b000};

  always_comb begin
    ld_data = mem_rsp_data_i;
    case (ld_size_q)
      2'b10:   ld_data = {24'b0, rsp_shift[7:0]};
      2'b01:   ld_data = ld_off_q[1] ? {16'b0, mem_rsp_data_i[31:16]}
                                     : {16'b0, mem_rsp_data_i[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ld_reg_d   = ld_reg_q;
    ld_off_d   = ld_off_q;
    ld_size_d  = ld_size_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      StIdle: begin
        if (req_hs && !h_store) begin
          ld_reg_d  = h_reg;
          ld_off_d  = h_addr[1:0];
          ld_size_d = h_size;
          state_d   = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (mem_rsp_valid_i) begin
          wb_valid_d = 1'b1;
          wb_reg_d   = ld_reg_q;
          wb_data_d  = ld_data;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_reg_q   <= '0;
      ld_off_q   <= '0;
      ld_size_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ld_reg_q   <= ld_reg_d;
      ld_off_q   <= ld_off_d;
      ld_size_q  <= ld_size_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {in_is_store_i, in_packet_i};
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_reg_o   = wb_reg_q;
  assign wb_data_o  = wb_data_q;
  assign busy_o     = (count_q != '0) || (state_q == StWaitRsp);
  assign count_o    = count_q;

endmodule

// File: tb/tb_ldst_lane_queue.sv
// Bench for ldst_lane_queue: directed scenarios plus random traffic, every cycle checked against
// a queue-based reference model.
module tb_ldst_lane_queue;

  localparam int AW = 32;
  localparam int RW = 7;
  localparam int DW = 32;
  localparam int D  = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid, in_is_store, in_ready;
  logic [AW+RW+DW+3:0] in_packet;
  logic               mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0]      mem_req_addr;
  logic [31:0]        mem_req_wdata;
  logic [3:0]         mem_req_be;
  logic [1:0]         mem_req_space;
  logic               mem_rsp_valid;
  logic [31:0]        mem_rsp_data;
  logic               wb_valid;
  logic [RW-1:0]      wb_reg;
  logic [31:0]        wb_data;
  logic               busy;
  logic [2:0]         count;

  always #5 clk = ~clk;

  ldst_lane_queue #(.ADDR_W(AW), .DATA_W(DW), .REG_W(RW), .DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_packet_i(in_packet),
    .in_is_store_i(in_is_store), .in_ready_o(in_ready), .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready), .mem_req_we_o(mem_req_we), .mem_req_addr_o(mem_req_addr),
    .mem_req_wdata_o(mem_req_wdata), .mem_req_be_o(mem_req_be),
    .mem_req_space_o(mem_req_space), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i(mem_rsp_data), .wb_valid_o(wb_valid), .wb_reg_o(wb_reg),
    .wb_data_o(wb_data), .busy_o(busy), .count_o(count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  rg;
    logic [31:0] wdata;
    logic [1:0]  space;
    logic [1:0]  size;
    logic        st;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  ent_t        cur;
  bit          m_wait;
  logic [6:0]  m_lreg;
  logic [1:0]  m_loff, m_lsize;
  logic        m_wbv;
  logic [6:0]  m_wbr;
  logic [31:0] m_wbd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_st_data(input ent_t e);
    case (e.size)
      2'b10:   return {24'b0, e.wdata[7:0]} * 32'h0101_0101;
      2'b01:   return {16'b0, e.wdata[15:0]} * 32'h0001_0001;
      default: return e.wdata;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input ent_t e);
    int lane = int'(e.addr % 4);
    if (!e.st) return 4'hF;
    case (e.size)
      2'b10:   return 4'(1 << lane);
      2'b01:   return (lane >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_ld(input logic [31:0] rsp, input logic [1:0] lane,
                                         input logic [1:0] size);
    case (size)
      2'b10:   return (rsp >> (8 * int'(lane))) & 32'hFF;
      2'b01:   return (lane >= 2) ? (rsp >> 16) : (rsp & 32'hFFFF);
      default: return rsp;
    endcase
  endfunction

  task automatic set_in(input bit v, input bit st, input logic [31:0] a, input logic [6:0] r,
                        input logic [31:0] w, input logic [1:0] sp, input logic [1:0] sz);
    cur.addr = a; cur.rg = r; cur.wdata = w; cur.space = sp; cur.size = sz; cur.st = st;
    in_valid    = v;
    in_is_store = st;
    in_packet   = {a, r, w, sp, sz};
  endtask

  // Checks every output against the model mid-cycle, then advances the model one clock.
  task automatic cycle();
    ent_t e;
    bit   exp_rv, hs, push, nwbv;
    @(negedge clk);
    exp_rv = !m_wait && (mq.size() != 0);
    chk("in_ready", in_ready, mq.size() < D);
    chk("req_valid", mem_req_valid, exp_rv);
    if (exp_rv) begin
      e = mq[0];
      chk("req_addr", mem_req_addr, e.addr & ~32'h3);
      chk("req_we", mem_req_we, e.st);
      chk("req_be", mem_req_be, exp_be(e));
      chk("req_space", mem_req_space, e.space);
      if (e.st) chk("req_wdata", mem_req_wdata, exp_st_data(e));
    end
    chk("count", count, mq.size());
    chk("busy", busy, (mq.size() != 0) || m_wait);
    chk("wb_valid", wb_valid, m_wbv);
    chk("wb_reg", wb_reg, m_wbr);
    chk("wb_data", wb_data, m_wbd);
    hs   = exp_rv && mem_req_ready;
    push = in_valid && (mq.size() < D);
    nwbv = 1'b0;
    if (m_wait && mem_rsp_valid) begin
      nwbv   = 1'b1;
      m_wbr  = m_lreg;
      m_wbd  = exp_ld(mem_rsp_data, m_loff, m_lsize);
      m_wait = 1'b0;
    end
    if (hs) begin
      e = mq.pop_front();
      if (!e.st) begin
        m_wait  = 1'b1;
        m_lreg  = e.rg;
        m_loff  = e.addr[1:0];
        m_lsize = e.size;
      end
    end
    if (push) mq.push_back(cur);
    m_wbv = nwbv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid      = 1'b0;
    mem_rsp_valid = 1'b0;
    rst_n         = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    mq.delete();
    m_wait = 1'b0;
    m_wbv  = 1'b0;
    m_wbr  = '0;
    m_wbd  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_drain(input logic [31:0] base);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b1, base + 32'(i * 4), 7'(i), 32'hA500_0000 + 32'(i), 2'(i), 2'b00);
      cycle();
    end
    in_valid = 1'b0;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", mem_req_addr, base + 32'(i * 4));
      cycle();
    end
    chk("drain_empty", count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_valid = 0; in_is_store = 0; in_packet = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    cur = '{default: '0};
    do_reset();
    cycle();
    cycle();

    fill_drain(32'h0000_0100);

    // Store byte lane, held with ready low so the fields can be inspected.
    mem_req_ready = 1'b0;
    set_in(1'b1, 1'b1, 32'h1003, 7'd0, 32'h0000_00AB, 2'b01, 2'b10);
    cycle();
    in_valid = 1'b0;
    chk("stb_addr", mem_req_addr, 32'h1000);
    chk("stb_wdata", mem_req_wdata, 32'hABAB_ABAB);
    chk("stb_be", mem_req_be, 4'b1000);
    chk("stb_we", mem_req_we, 1);
    cycle();
    mem_req_ready = 1'b1;
    cycle();

    // Pointers now sit off zero, so this fill wraps.
    fill_drain(32'h0000_0200);

    // Load half upper.
    set_in(1'b1, 1'b0, 32'h2002, 7'd5, 32'h0, 2'b00, 2'b01);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("ldh_wait_noreq", mem_req_valid, 0);
    cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBEEF_1234;
    cycle();
    mem_rsp_valid = 1'b0;
    chk("ldh_wb_valid", wb_valid, 1);
    chk("ldh_wb_reg", wb_reg, 5);
    chk("ldh_wb_data", wb_data, 32'h0000_BEEF);
    cycle();
    chk("ldh_wb_pulse", wb_valid, 0);

    // Load byte followed by a store that must wait for the response.
    set_in(1'b1, 1'b0, 32'h3001, 7'd9, 32'h0, 2'b10, 2'b10);
    cycle();
    set_in(1'b1, 1'b1, 32'h3100, 7'd0, 32'hCAFE_F00D, 2'b01, 2'b00);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("ord_store_held", mem_req_valid, 0);
    chk("ord_count", count, 1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1122_3344;
    cycle();
    mem_rsp_valid = 1'b0;
    chk("ord_wb_data", wb_data, 32'h0000_0033);
    chk("ord_store_issue", mem_req_valid, 1);
    chk("ord_store_addr", mem_req_addr, 32'h3100);
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom % 2), 1'($urandom % 2), $urandom, 7'($urandom), $urandom,
             2'($urandom), 2'($urandom));
      mem_req_ready = ($urandom % 4) != 0;
      mem_rsp_valid = ($urandom % 3) == 0;
      mem_rsp_data  = $urandom;
      cycle();
    end
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      mem_rsp_data = $urandom;
      cycle();
    end
    mem_rsp_valid = 1'b0;
    cycle();

    // Reset while a load is outstanding with two entries queued.
    set_in(1'b1, 1'b0, 32'h4000, 7'd3, 32'h0, 2'b00, 2'b00);
    cycle();
    set_in(1'b1, 1'b1, 32'h4004, 7'd0, 32'h1, 2'b00, 2'b00);
    cycle();
    set_in(1'b1, 1'b1, 32'h4008, 7'd0, 32'h2, 2'b00, 2'b00);
    cycle();
    in_valid = 1'b0;
    chk("mid_count", count, 2);
    chk("mid_busy", busy, 1);
    do_reset();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hFFFF_FFFF;
    cycle();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_no_wb", wb_valid, 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldst_lane_queue.md
# ldst_lane_queue

Per-lane load/store request queue sitting directly downstream of the LDST lane address stage. It accepts one lane packet per cycle (`{addr, loadReg, storeData, ldstSpace, ldstSize}`) and buffers it in a small FIFO. It issues requests in order to the data memory port over a valid/ready handshake, with at most one load outstanding. It formats store byte lanes and load return data, and produces a registered register-file writeback for loads.

## Interface
- `ADDR_W`, 32, address width (`SIZE_ADDR`)
- `DATA_W`, 32, data width (`SIZE_DATA`); fixed at 32 for lane formatting
- `REG_W`, 7, destination register tag width (`SIZE_REGFILE_BR`)
- `DEPTH`, 4, FIFO entries, power of two, ≥2
- `clk` in 1 — single clock, all state on rising edge
- `reset` in 1 — asynchronous, active-low
- `in_valid` in 1 — lane packet valid
- `in_packet` in ADDR_W+REG_W+DATA_W+4 — `{addr, reg, wdata, space[1:0], size[1:0]}`, MSB first
- `in_is_store` in 1 — 1 = store, 0 = load
- `in_ready` out 1 — queue can accept
- `mem_req_valid` out 1 — request valid
- `mem_req_ready` in 1 — memory accepts request
- `mem_req_we` out 1 — store
- `mem_req_addr` out ADDR_W — word-aligned address (`addr[1:0]` forced 0)
- `mem_req_wdata` out 32 — lane-replicated store data
- `mem_req_be` out 4 — byte enables (all ones for loads)
- `mem_req_space` out 2 — ldstSpace passthrough
- `mem_rsp_valid` in 1 — load data return
- `mem_rsp_data` in 32 — returned word
- `wb_valid` out 1 — writeback strobe
- `wb_reg` out REG_W — destination tag
- `wb_data` out 32 — formatted load result
- `busy` out 1 — FIFO non-empty or load outstanding
- `count` out $clog2(DEPTH)+1 — FIFO occupancy

## Operation
- FIFO storage: circular buffer with wr/rd pointers and an occupancy counter. Push = `in_valid & in_ready`; pop = request handshake.
- `in_ready = (count != DEPTH)`. No push when full, even if a pop occurs in the same cycle. Simultaneous push and pop leaves `count` unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: `mem_req_valid = (count != 0)`. Request fields are driven combinationally from the head entry.
  - On handshake with a store: pop and stay in IDLE.
  - On handshake with a load: pop, latch reg, `addr[1:0]`, size, then go to WAIT_RSP.
  - WAIT_RSP: `mem_req_valid = 0`. On `mem_rsp_valid`, register the writeback and return to IDLE.
- `mem_rsp_valid` in IDLE is ignored.
- Size encoding: 00 word, 01 half, 10 byte, 11 treated as word.
- Store formatting:
  - Byte: wdata = `{4{wdata[7:0]}}`, be = one-hot(`addr[1:0]`).
  - Half: wdata = `{2{wdata[15:0]}}`, be = `addr[1]` ? 1100 : 0011; `addr[0]` is ignored.
  - Word: be = 1111.
- Load formatting, zero-extended:
  - Byte: `rsp >> (8*addr[1:0])` masked to 8 bits.
  - Half: `addr[1]` ? `rsp[31:16]` : `rsp[15:0]`.
  - Word: unchanged.
- `busy = (count != 0) | (state == WAIT_RSP)`.

## Timing
- Reset (async assert, `reset = 0`):
  - State = IDLE; pointers and `count` = 0.
  - `wb_valid`, `wb_reg`, `wb_data` = 0.
  - Hence `in_ready = 1`, `mem_req_valid = 0`, `busy = 0`.
  - FIFO contents are don't-care.
  - Reset mid-operation discards all entries and any outstanding load; a late response after release is ignored (IDLE).
- Latency:
  - A pushed packet is visible at the head the next cycle. Earliest `mem_req_valid` is 1 cycle after push into an empty queue.
  - `wb_valid` asserts exactly 1 cycle after `mem_rsp_valid` in WAIT_RSP, for exactly 1 cycle.
- Request fields are stable while `mem_req_valid = 1` and `mem_req_ready = 0`.
- Back-to-back stores issue one per cycle while `mem_req_ready = 1`.
- A response arriving in the same cycle as the load handshake is not accepted; the response must come ≥1 cycle later.
- After a response, the next request may issue in the cycle following the response.

## Test plan
- Reset then idle: `reset = 0`, then 1 → `in_ready = 1`, `mem_req_valid = 0`, `count = 0`, `wb_valid = 0`, `busy = 0`.
- Fill/full:
  - Push 5 stores with `mem_req_ready = 0`, DEPTH = 4 → `count = 4`, `in_ready = 0`, 5th not accepted.
  - Then `mem_req_ready = 1` → 4 stores issue on 4 consecutive cycles in order.
  - Pointers wrap correctly on a second fill.
- Store byte lane: store size 10, addr 0x1003, wdata 0x000000AB → `mem_req_addr = 0x1000`, `wdata = 0xABABABAB`, `be = 1000`, `we = 1`.
- Load half upper:
  - Load size 01, addr 0x2002, reg 5.
  - Handshake, then `mem_rsp_data = 0xBEEF1234` two cycles later → next cycle `wb_valid = 1`, `wb_reg = 5`, `wb_data = 0x0000BEEF`.
  - No request issues while in WAIT_RSP.
- Load byte then store ordering:
  - Queue load (size 10, addr 0x3001, reg 9) then a store.
  - The store is held until the response `0x11223344` arrives → `wb_data = 0x00000033`; the store issues the following cycle.
- Reset mid-load: assert `reset` in WAIT_RSP with 2 entries queued → `count = 0`, `busy = 0`; a subsequent `mem_rsp_valid` produces no `wb_valid`.
